// File: rtl/uart_tx.sv
// uart_tx: byte FIFO feeding an 8N1 serializer.
// Bytes are pushed into a power-of-two FIFO. The serializer pops the head byte
// and sends start, eight data bits LSB first and one stop bit, each for
// CLKS_PER_BIT clocks. The line is registered and follows the FSM state by one
// clock, so a byte accepted on edge N drives tx low after edge N+2.
//
// Handshake: a byte transfers on a rising edge where tx_valid && tx_ready.
// tx_ready depends only on fifo_count, never on tx_valid, so a full FIFO
// refuses a push even on an edge where the serializer pops.
module uart_tx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [1:0]                    dbg_state
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int AW           = $clog2(FIFO_DEPTH);
  localparam int CW           = AW + 1;
  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  // FIFO storage and bookkeeping
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          push;
  logic          pop;

  // Serializer state
  state_e        state_q;
  logic [15:0]   clk_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          bit_done;

  assign tx_ready   = (count_q != CW'(FIFO_DEPTH));
  assign push       = tx_valid && tx_ready;
  assign bit_done   = (clk_cnt_q == BIT_LAST);
  // Pop when idle with data, or at the last clock of a stop bit so the next
  // start bit follows with no idle gap.
  assign pop        = (count_q != '0) &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_done));
  assign tx         = tx_q;
  assign busy       = (state_q != IDLE);
  assign fifo_count = count_q;
  assign dbg_state  = state_q;

  // Occupancy next-state: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO data write; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  // FIFO pointers and count; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Serializer FSM; tx is registered from the current state (one-clock lag)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift_q   <= mem_q[rd_ptr_q];
            clk_cnt_q <= '0;
            state_q   <= START;
          end
        end
        START: begin
          tx_q <= 1'b0;
          if (bit_done) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= DATA;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        DATA: begin
          tx_q <= shift_q[bit_idx_q];
          if (bit_done) begin
            clk_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (bit_done) begin
            clk_cnt_q <= '0;
            if (pop) begin
              shift_q <= mem_q[rd_ptr_q];
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: random and directed byte streams checked every clock
// against a frame-timeline model, plus a serial decoder on the tx line.
module tb_uart_tx;

  localparam int CLK_FREQ  = 1_000_000;
  localparam int BAUD_RATE = 100_000;
  localparam int DEPTH     = 16;
  localparam int CPB       = CLK_FREQ / BAUD_RATE;
  localparam int FRAME     = 10 * CPB;

  // ---------------- clock / reset ----------------
  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx;
  logic       busy;
  logic [4:0] fifo_count;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_tx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx        (tx),
    .busy      (busy),
    .fifo_count(fifo_count),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model state ----------------
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] m_q[$];        // bytes waiting in the modelled FIFO
  logic [7:0] exp_q[$];      // bytes expected on the serial line, in order
  bit         m_active = 1'b0;
  int         m_pos    = 0;  // clock index within the current frame
  logic [7:0] m_byte   = 8'h00;
  logic       exp_tx   = 1'b1;
  int         busy_cycles = 0;
  bit         rx_busy  = 1'b0;
  int         rx_cnt   = 0;
  logic [7:0] rx_byte  = 8'h00;
  int         rx_frames = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Line level of a frame at bit slot k: 0 start, 1..8 data LSB first, 9 stop
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic void model_reset();
    m_q.delete();
    exp_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    exp_tx   = 1'b1;
    rx_busy  = 1'b0;
  endfunction

  // Advance the model across one rising edge using the pre-edge inputs
  function automatic void model_edge();
    bit do_push;
    bit do_pop;
    if (!rst_n) begin
      model_reset();
      return;
    end
    do_push = tx_valid && (m_q.size() != DEPTH);
    do_pop  = (m_q.size() != 0) && (!m_active || m_pos == FRAME - 1);
    exp_tx  = m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1;
    if (do_pop) begin
      m_byte   = m_q.pop_front();
      m_active = 1'b1;
      m_pos    = 0;
    end else if (m_active) begin
      if (m_pos == FRAME - 1) m_active = 1'b0;
      else m_pos++;
    end
    if (do_push) begin
      m_q.push_back(tx_data);
      exp_q.push_back(tx_data);
    end
  endfunction

  // Independent serial decoder sampling the middle of each bit
  task automatic rx_sample();
    if (!rst_n) begin
      rx_busy = 1'b0;
      return;
    end
    if (!rx_busy) begin
      if (tx === 1'b0) begin
        rx_busy = 1'b1;
        rx_cnt  = 0;
      end
    end else begin
      rx_cnt++;
      if ((rx_cnt % CPB == CPB / 2) && rx_cnt > CPB && rx_cnt < 9 * CPB)
        rx_byte[rx_cnt / CPB - 1] = tx;
      if (rx_cnt == 9 * CPB + CPB / 2) begin
        check_eq("rx_stop", 32'(tx), 32'd1);
        check_eq("rx_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("rx_byte", 32'(rx_byte), 32'(exp_q.pop_front()));
        rx_busy = 1'b0;
        rx_frames++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_eq("tx", 32'(tx), 32'(exp_tx));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("tx_ready", 32'(tx_ready), 32'(m_q.size() != DEPTH));
    check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
    if (busy) busy_cycles++;
    rx_sample();
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_valid = 1'b1;
    tx_data  = b;
    tick();
    tx_valid = 1'b0;
  endtask

  // Drop reset between edges, check outputs at once, then release
  task automatic async_reset();
    @(negedge clk);
    #2;
    tx_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_tx", 32'(tx), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_ready", 32'(tx_ready), 32'd1);
    check_eq("rst_count", 32'(fifo_count), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_active || m_q.size() != 0 || rx_busy) && n < (DEPTH + 4) * FRAME) begin
      tick();
      n++;
    end
    check_eq("drain_timeout", 32'(n < (DEPTH + 4) * FRAME), 32'd1);
    repeat (5) tick();
    check_eq("drain_all_rx", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int f0;
    int highs;
    bit saw_full;
    bit ok;

    // Reset
    async_reset();
    repeat (3) tick();

    // Single byte 0xA5: latency, busy width, decoded value
    busy_cycles = 0;
    f0 = rx_frames;
    push_byte(8'hA5);
    k = 0;
    while (tx !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    check_eq("latency", 32'(k), 32'd2);
    repeat (FRAME + 20) tick();
    check_eq("single_busy", 32'(busy_cycles), 32'(FRAME));
    check_eq("single_frames", 32'(rx_frames - f0), 32'd1);

    // Burst of three back-to-back bytes
    busy_cycles = 0;
    f0 = rx_frames;
    tx_valid = 1'b1;
    tx_data = 8'h00; tick();
    tx_data = 8'hFF; tick();
    tx_data = 8'h55; tick();
    tx_valid = 1'b0;
    drain();
    check_eq("burst_busy", 32'(busy_cycles), 32'(3 * FRAME));
    check_eq("burst_frames", 32'(rx_frames - f0), 32'd3);

    // Hold valid for 40 cycles with incrementing data to fill the FIFO
    saw_full = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tx_valid = 1'b1;
      tx_data  = 8'(i);
      tick();
      if (fifo_count == 5'(DEPTH)) saw_full = 1'b1;
    end
    tx_valid = 1'b0;
    check_eq("saw_full", 32'(saw_full), 32'd1);
    drain();

    // Reset in the middle of data bit 3 of the first of two frames
    f0 = rx_frames;
    tx_valid = 1'b1;
    tx_data = 8'h3C; tick();
    tx_data = 8'hC3; tick();
    tx_valid = 1'b0;
    k = 0;
    while (tx !== 1'b0 && k < 20) begin
      tick();
      k++;
    end
    check_eq("mid_start_seen", 32'(k < 20), 32'd1);
    repeat (4 * CPB + 4) tick();
    async_reset();
    highs = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (tx === 1'b1) highs++;
    end
    check_eq("mid_quiet", 32'(highs), 32'd200);
    check_eq("mid_frames", 32'(rx_frames - f0), 32'd0);

    // Random pushes
    for (int i = 0; i < 800; i++) begin
      tx_valid = ($urandom_range(0, 3) == 0);
      tx_data  = 8'($urandom_range(0, 255));
      tick();
    end
    tx_valid = 1'b0;
    drain();

    // Loopback of every byte value
    f0 = rx_frames;
    ok = 1'b1;
    for (int b = 0; b < 256; b++) begin
      k = 0;
      while (tx_ready !== 1'b1 && k < 3 * FRAME) begin
        tick();
        k++;
      end
      if (k >= 3 * FRAME) ok = 1'b0;
      push_byte(8'(b));
    end
    check_eq("loop_ready_wait", 32'(ok), 32'd1);
    drain();
    check_eq("loop_frames", 32'(rx_frames - f0), 32'd256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, the clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, the serial bit rate in bits/s.
REQ-003 Parameter FIFO_DEPTH, default 16, the transmit FIFO depth in bytes; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  the single clock; all state is updated on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 tx_data  input  8  byte to enqueue.
REQ-007 tx_valid  input  1  a byte is presented on tx_data.
REQ-008 tx_ready  output  1  the FIFO can accept a byte (not full).
REQ-009 tx  output  1  serial line, registered, idle high.
REQ-010 busy  output  1  the serializer is inside a frame.
REQ-011 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued and not yet popped.

Function
REQ-012 CLKS_PER_BIT SHALL equal CLK_FREQ/BAUD_RATE (integer division), and the bit counter SHALL be 16 bits wide.
REQ-013 Every bit, including start and stop, SHALL be driven for exactly CLKS_PER_BIT clk cycles.
REQ-014 Frame format SHALL be 8N1: start bit 0, data[0] through data[7] (LSB first), one full stop bit 1; a frame lasts 10*CLKS_PER_BIT cycles.
REQ-015 A push SHALL occur on a rising edge where tx_valid && tx_ready, and tx_data is written at the write pointer.
REQ-016 tx_ready SHALL equal (fifo_count != FIFO_DEPTH).
- When full, a push is refused even if a pop occurs on the same edge.
REQ-017 A simultaneous push and pop SHALL leave fifo_count unchanged and SHALL keep byte order.
REQ-018 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 Serializer FSM states SHALL be IDLE, START, DATA and STOP, and busy SHALL equal (state != IDLE).
REQ-020 IDLE: tx=1. If fifo_count != 0, the FSM SHALL pop the head byte into the shift register, clear the bit counter and enter START.
REQ-021 START: tx=0 for CLKS_PER_BIT cycles, then the FSM SHALL enter DATA with bit index 0.
REQ-022 DATA: tx equals shift[bit index] for CLKS_PER_BIT cycles per bit. After index 7 the FSM SHALL enter STOP.
REQ-023 STOP: tx=1 for CLKS_PER_BIT cycles. At the end of the stop bit:
- FIFO non-empty: pop and enter START directly (no idle cycle between frames).
- FIFO empty: enter IDLE.
REQ-024 Latency: for an empty, idle block, tx SHALL fall on the 2nd rising edge after the edge that accepts the byte.
REQ-025 tx_data and tx_valid changes SHALL NOT affect a frame in progress, because the byte is latched at pop.

Reset
REQ-026 On assertion of rst_n=0, asynchronously and without waiting for clk:
- tx=1, busy=0, state=IDLE;
- FIFO pointers and fifo_count cleared, so tx_ready=1;
- counters cleared.
REQ-027 Reset mid-frame SHALL abandon the frame; after rst_n deasserts, no part of that frame or any previously queued byte is transmitted.
REQ-028 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification (CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10; FIFO_DEPTH=16)
REQ-029 Reset: assert rst_n=0 between clock edges -> immediately tx=1, busy=0, tx_ready=1, fifo_count=0.
REQ-030 Single byte: push 0xA5 -> tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each for 10 cycles; busy is high for exactly 100 cycles; tx falls 2 edges after the push.
REQ-031 Burst: push 0x00, 0xFF, 0x55 on consecutive cycles -> 300 contiguous frame cycles, the stop bit of each frame is followed directly by the next start bit, and bytes go out in order.
REQ-032 Full: hold tx_valid with incrementing data for 40 cycles starting from idle -> tx_ready falls when fifo_count=16, pushes are refused while full, and the accepted bytes are transmitted in order with none duplicated or lost.
REQ-033 Reset mid-frame: push 0x3C and 0xC3, then drop rst_n during data bit 3 -> tx=1 at once; after release, tx stays high for 200 cycles.
REQ-034 Loopback: connect tx to the team's UART receiver and push 0x00 through 0xFF -> all 256 bytes are received identical and in order.
